boss_hp_ctl: RTL and testbench

- Boss-side receiver of the player weapon hit signals, `melee_hit` and `projectile_hit`.
- Converts hit edges into damage, holds boss health and enforces invulnerability frames after each accepted hit.
- Sequences boss death and drives `boss_alive` back to the weapon, boss draw and game-state logic.
- Sits beside the boss modules in the top level, clocked by the pixel clock and paced by `frame_tick`.

---
 rtl/boss_hp_ctl.sv | 144 ++++++++++++++
 tb/tb_boss_hp_ctl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/boss_hp_ctl.sv
// Boss health controller: turns weapon hit edges into damage, enforces
// invulnerability frames, and sequences the death animation.
module boss_hp_ctl #(
    parameter int HP_MAX       = 100,
    parameter int HP_W         = 8,
    parameter int MELEE_DMG    = 5,
    parameter int PROJ_DMG     = 2,
    parameter int IFRAMES      = 8,
    parameter int DEATH_FRAMES = 30
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_tick,
    input  logic [1:0]      game_active,
    input  logic            melee_hit,
    input  logic            projectile_hit,
    output logic            boss_alive,
    output logic [HP_W-1:0] boss_hp,
    output logic            boss_hit_flash,
    output logic            boss_dying,
    output logic            boss_defeated
);

    localparam int CNT_MAX = (IFRAMES > DEATH_FRAMES) ? IFRAMES : DEATH_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACTIVE = 3'd1,
        IFRAME = 3'd2,
        DYING  = 3'd3,
        DEAD   = 3'd4
    } state_t;

    state_t          state_q, state_n;
    logic [HP_W-1:0] hp_q, hp_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic            defeated_q, defeated_n;
    logic            melee_q, proj_q;
    logic            melee_edge, proj_edge;
    logic [HP_W:0]   dmg, hp_ext;
    logic            running;

    assign melee_edge = melee_hit & ~melee_q;
    assign proj_edge  = projectile_hit & ~proj_q;
    assign running    = (game_active == 2'd1);
    assign hp_ext     = {1'b0, hp_q};

    // Damage is summed one bit wider than the health so a double hit on a
    // nearly-full bar can never overflow before the saturation compare.
    always_comb begin
        dmg = '0;
        if (melee_edge) dmg = dmg + (HP_W+1)'(MELEE_DMG);
        if (proj_edge)  dmg = dmg + (HP_W+1)'(PROJ_DMG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hp_q       <= HP_W'(HP_MAX);
            cnt_q      <= '0;
            defeated_q <= 1'b0;
            melee_q    <= 1'b0;
            proj_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            hp_q       <= hp_n;
            cnt_q      <= cnt_n;
            defeated_q <= defeated_n;
            melee_q    <= melee_hit;
            proj_q     <= projectile_hit;
        end
    end

    always_comb begin
        state_n    = state_q;
        hp_n       = hp_q;
        cnt_n      = cnt_q;
        defeated_n = 1'b0;
        // Leaving the fight outranks anything else happening this cycle.
        if (state_q != IDLE && !running) begin
            state_n = IDLE;
            hp_n    = HP_W'(HP_MAX);
            cnt_n   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    hp_n  = HP_W'(HP_MAX);
                    cnt_n = '0;
                    if (running) state_n = ACTIVE;
                end
                ACTIVE: begin
                    cnt_n = '0;
                    if (dmg != '0) begin
                        if (dmg >= hp_ext) begin
                            hp_n    = '0;
                            state_n = DYING;
                        end else begin
                            hp_n    = hp_q - dmg[HP_W-1:0];
                            state_n = IFRAME;
                        end
                    end
                end
                IFRAME: begin
                    if (frame_tick) begin
                        if (cnt_q == CNT_W'(IFRAMES - 1)) begin
                            cnt_n   = '0;
                            state_n = ACTIVE;
                        end else begin
                            cnt_n = cnt_q + 1'b1;
                        end
                    end
                end
                DYING: begin
                    if (frame_tick) begin
                        if (cnt_q == CNT_W'(DEATH_FRAMES - 1)) begin
                            cnt_n      = '0;
                            state_n    = DEAD;
                            defeated_n = 1'b1;
                        end else begin
                            cnt_n = cnt_q + 1'b1;
                        end
                    end
                end
                DEAD: begin
                    hp_n  = '0;
                    cnt_n = '0;
                end
                default: begin
                    state_n = IDLE;
                    hp_n    = HP_W'(HP_MAX);
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign boss_alive     = (state_q == ACTIVE) || (state_q == IFRAME);
    assign boss_hp        = hp_q;
    assign boss_hit_flash = (state_q == IFRAME);
    assign boss_dying     = (state_q == DYING);
    assign boss_defeated  = defeated_q;

endmodule

// File: tb/tb_boss_hp_ctl.sv
// Directed bench for boss_hp_ctl: expected output changes, stamped with the
// cycle they must appear in, are queued and matched by an independent monitor.
module tb_boss_hp_ctl;

    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic [1:0] game_active;
    logic       melee_hit;
    logic       projectile_hit;
    logic       boss_alive;
    logic [7:0] boss_hp;
    logic       boss_hit_flash;
    logic       boss_dying;
    logic       boss_defeated;

    logic [W-1:0] exp_q[$];
    logic [19:0]  cyc = '0;
    logic [11:0]  prev_vec = 'x;
    int checks = 0;
    int errors = 0;

    boss_hp_ctl dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .game_active    (game_active),
        .melee_hit      (melee_hit),
        .projectile_hit (projectile_hit),
        .boss_alive     (boss_alive),
        .boss_hp        (boss_hp),
        .boss_hit_flash (boss_hit_flash),
        .boss_dying     (boss_dying),
        .boss_defeated  (boss_defeated)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1'b1;

    function automatic logic [11:0] vec(input logic a, input int hp, input logic f,
                                        input logic d, input logic x);
        logic [7:0] h;
        h = 8'(hp);
        return {a, h, f, d, x};
    endfunction

    // driver tasks
    task automatic push_at(input int off, input logic [11:0] v);
        logic [19:0] t;
        t = cyc + 20'(off);
        exp_q.push_back({t, v});
    endtask

    task automatic push(input logic [11:0] v);
        push_at(1, v);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            repeat (3) cycle();
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
        end
    endtask

    task automatic tick_push(input logic [11:0] v);
        repeat (3) cycle();
        frame_tick = 1'b1;
        push(v);
        cycle();
        frame_tick = 1'b0;
    endtask

    task automatic melee_pulse(input logic [11:0] v);
        melee_hit = 1'b1;
        push(v);
        cycle();
        melee_hit = 1'b0;
    endtask

    // scoreboard monitor: any change of the output bundle must match the head
    always @(negedge clk) begin
        logic [11:0]  cur;
        logic [W-1:0] e;
        cur = {boss_alive, boss_hp, boss_hit_flash, boss_dying, boss_defeated};
        if (cur !== prev_vec) begin
            prev_vec = cur;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got alive=%b hp=%0d flash=%b dying=%b def=%b, required no change",
                         cyc, cur[11], cur[10:3], cur[2], cur[1], cur[0]);
            end else begin
                e = exp_q.pop_front();
                if (e !== {cyc, cur}) begin
                    errors++;
                    $display("FAIL output_change got cyc=%0d alive=%b hp=%0d flash=%b dying=%b def=%b, required cyc=%0d alive=%b hp=%0d flash=%b dying=%b def=%b",
                             cyc, cur[11], cur[10:3], cur[2], cur[1], cur[0],
                             e[31:12], e[11], e[10:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hp;
        rst = 1'b1; frame_tick = 1'b0; game_active = 2'd0;
        melee_hit = 1'b0; projectile_hit = 1'b0;
        exp_q.push_back({20'd1, vec(0, 100, 0, 0, 0)});
        repeat (3) cycle();
        rst = 1'b0;

        // start fight, single melee hit, 8-frame invulnerability
        game_active = 2'd1;
        push(vec(1, 100, 0, 0, 0));
        cycle();
        repeat (2) cycle();
        melee_pulse(vec(1, 95, 1, 0, 0));
        frames(7);
        tick_push(vec(1, 95, 0, 0, 0));

        // held level: one hit only, held through and past the window
        melee_hit = 1'b1;
        push(vec(1, 90, 1, 0, 0));
        cycle();
        frames(7);
        tick_push(vec(1, 90, 0, 0, 0));
        frames(12);
        melee_hit = 1'b0;
        repeat (2) cycle();

        // simultaneous edges, then a discarded projectile inside the window
        melee_hit = 1'b1; projectile_hit = 1'b1;
        push(vec(1, 83, 1, 0, 0));
        cycle();
        melee_hit = 1'b0; projectile_hit = 1'b0;
        frames(3);
        projectile_hit = 1'b1;
        cycle();
        projectile_hit = 1'b0;
        cycle();
        frames(4);
        tick_push(vec(1, 83, 0, 0, 0));

        // wear health down to 3
        hp = 83;
        for (int i = 0; i < 16; i++) begin
            hp = hp - 5;
            melee_pulse(vec(1, hp, 1, 0, 0));
            frames(7);
            tick_push(vec(1, hp, 0, 0, 0));
        end

        // killing blow saturates at 0, death animation, defeated pulse
        melee_pulse(vec(0, 0, 0, 1, 0));
        cycle();
        projectile_hit = 1'b1;
        cycle();
        projectile_hit = 1'b0;
        frames(29);
        repeat (3) cycle();
        frame_tick = 1'b1;
        push_at(1, vec(0, 0, 0, 0, 1));
        push_at(2, vec(0, 0, 0, 0, 0));
        cycle();
        frame_tick = 1'b0;
        frames(2);

        // leave from DEAD, restart
        game_active = 2'd0;
        push(vec(0, 100, 0, 0, 0));
        cycle();
        game_active = 2'd1;
        push(vec(1, 100, 0, 0, 0));
        cycle();

        // abort during IFRAME with a coincident hit
        melee_pulse(vec(1, 95, 1, 0, 0));
        frames(2);
        game_active = 2'd0; projectile_hit = 1'b1;
        push(vec(0, 100, 0, 0, 0));
        cycle();
        projectile_hit = 1'b0;
        game_active = 2'd2;
        repeat (3) cycle();
        game_active = 2'd1;
        push(vec(1, 100, 0, 0, 0));
        cycle();
        melee_pulse(vec(1, 95, 1, 0, 0));
        frames(7);
        tick_push(vec(1, 95, 0, 0, 0));

        // reset mid-fight
        melee_pulse(vec(1, 90, 1, 0, 0));
        frames(2);
        rst = 1'b1;
        push(vec(0, 100, 0, 0, 0));
        cycle();
        cycle();
        rst = 1'b0;
        push(vec(1, 100, 0, 0, 0));
        cycle();
        repeat (5) cycle();

        // final report
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got %0d pending, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
